clock_gen: RTL and testbench



---
 rtl/clock_gen_if.sv | 25 ++
 rtl/clock_gen.sv | 124 ++++++++++++
 tb/tb_clock_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_gen_if.sv
// rtl/clock_gen_if.sv - control and output bundle for the clock_gen divider
// The master side requests runs and divisor changes; the slave side is the generator.
interface clock_gen_if #(
  parameter int DIV_W  = 8,
  parameter int PCNT_W = 16
);
  logic              en;
  logic [DIV_W-1:0]  div;
  logic              div_load;
  logic              clk_out;
  logic              rise_pulse;
  logic              fall_pulse;
  logic              running;
  logic [PCNT_W-1:0] period_cnt;

  modport master (
    output en, div, div_load,
    input  clk_out, rise_pulse, fall_pulse, running, period_cnt
  );

  modport slave (
    input  en, div, div_load,
    output clk_out, rise_pulse, fall_pulse, running, period_cnt
  );
endinterface

// File: rtl/clock_gen.sv
// rtl/clock_gen.sv - programmable registered clock divider with edge strobes
// Divisor and run changes are applied only at period boundaries, so clk_out never glitches.
module clock_gen #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int PCNT_W      = 16
) (
  input logic        clk,
  input logic        rst,
  clock_gen_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'((DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV);

  state_t            state;
  state_t            stateNext;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  cntNext;
  logic [DIV_W-1:0]  activeDiv;
  logic [DIV_W-1:0]  activeNext;
  logic [DIV_W-1:0]  pendingDiv;
  logic [DIV_W-1:0]  pendingNext;
  logic [DIV_W-1:0]  loadVal;
  logic [DIV_W-1:0]  lastCnt;
  logic [DIV_W:0]    highLen;
  logic [DIV_W:0]    cntInc;
  logic              boundary;
  logic              clkOut;
  logic              clkNext;
  logic              risePulse;
  logic              riseNext;
  logic              fallPulse;
  logic              fallNext;
  logic [PCNT_W-1:0] periodCnt;
  logic [PCNT_W-1:0] periodNext;

  assign loadVal     = (bus.div < DIV_W'(2)) ? DIV_W'(2) : bus.div;
  // Forwarding the load lets a div_load on a boundary edge shape the new period.
  assign pendingNext = bus.div_load ? loadVal : pendingDiv;
  assign lastCnt     = activeDiv - DIV_W'(1);
  assign highLen     = ({1'b0, activeDiv} + (DIV_W+1)'(1)) >> 1;
  assign cntInc      = {1'b0, cnt} + (DIV_W+1)'(1);
  assign boundary    = (cnt == lastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      activeDiv  <= RESET_DIV;
      pendingDiv <= RESET_DIV;
      clkOut     <= 1'b0;
      risePulse  <= 1'b0;
      fallPulse  <= 1'b0;
      periodCnt  <= '0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      activeDiv  <= activeNext;
      pendingDiv <= pendingNext;
      clkOut     <= clkNext;
      risePulse  <= riseNext;
      fallPulse  <= fallNext;
      periodCnt  <= periodNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.en) stateNext = RUN;
      RUN:     if (boundary && !bus.en) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    cntNext    = cnt;
    activeNext = activeDiv;
    clkNext    = clkOut;
    riseNext   = 1'b0;
    fallNext   = 1'b0;
    periodNext = periodCnt;
    case (state)
      IDLE: begin
        cntNext = '0;
        clkNext = 1'b0;
        if (bus.en) begin
          clkNext    = 1'b1;
          riseNext   = 1'b1;
          periodNext = periodCnt + PCNT_W'(1);
          activeNext = pendingNext;
        end
      end
      RUN: begin
        if (!boundary) begin
          cntNext  = cntInc[DIV_W-1:0];
          clkNext  = (cntInc < highLen);
          fallNext = clkOut && !clkNext;
        end else if (bus.en) begin
          cntNext    = '0;
          clkNext    = 1'b1;
          riseNext   = 1'b1;
          periodNext = periodCnt + PCNT_W'(1);
          activeNext = pendingNext;
        end else begin
          // Boundary is only reached in the low phase, so stopping here never clips a high.
          cntNext = '0;
          clkNext = 1'b0;
        end
      end
      default: begin
        cntNext = '0;
        clkNext = 1'b0;
      end
    endcase
  end

  assign bus.clk_out    = clkOut;
  assign bus.rise_pulse = risePulse;
  assign bus.fall_pulse = fallPulse;
  assign bus.running    = (state == RUN);
  assign bus.period_cnt = periodCnt;
endmodule

// File: tb/tb_clock_gen.sv
// tb/tb_clock_gen.sv - directed self-checking bench for clock_gen
// Inputs change and outputs are sampled 1ns after each rising clk edge.
module tb_clock_gen;
  localparam int DIV_W  = 8;
  localparam int PCNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  clock_gen_if #(.DIV_W(DIV_W), .PCNT_W(PCNT_W)) bus ();

  clock_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(2), .PCNT_W(PCNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.div_load = 1'b0;
    bus.div = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic preload(input logic [DIV_W-1:0] v);
    bus.div = v;
    bus.div_load = 1'b1;
    tick;
    bus.div_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.div_load = 1'b0;
    bus.div = '0;
    tick;
    tick;
    checks++; if (bus.clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", bus.clk_out); end
    checks++; if (bus.rise_pulse !== 1'b0) begin failures++; $display("FAIL reset_rise got=%b exp=0", bus.rise_pulse); end
    checks++; if (bus.fall_pulse !== 1'b0) begin failures++; $display("FAIL reset_fall got=%b exp=0", bus.fall_pulse); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    checks++; if (bus.period_cnt !== 16'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", bus.period_cnt); end
  endtask

  task automatic test_default_div;
    logic              expClk;
    logic [PCNT_W-1:0] expPer;
    do_reset;
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      expClk = (i % 2 == 0);
      expPer = PCNT_W'(i / 2 + 1);
      checks++; if (bus.clk_out !== expClk) begin failures++; $display("FAIL div2_clk[%0d] got=%b exp=%b", i, bus.clk_out, expClk); end
      checks++; if (bus.rise_pulse !== expClk) begin failures++; $display("FAIL div2_rise[%0d] got=%b exp=%b", i, bus.rise_pulse, expClk); end
      checks++; if (bus.fall_pulse !== !expClk) begin failures++; $display("FAIL div2_fall[%0d] got=%b exp=%b", i, bus.fall_pulse, !expClk); end
      checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL div2_running[%0d] got=%b exp=1", i, bus.running); end
      checks++; if (bus.period_cnt !== expPer) begin failures++; $display("FAIL div2_period[%0d] got=%0d exp=%0d", i, bus.period_cnt, expPer); end
    end
  endtask

  task automatic test_div5;
    logic [0:9]        clkPat;
    logic [0:9]        risePat;
    logic [0:9]        fallPat;
    logic [PCNT_W-1:0] expPer;
    clkPat  = 10'b1110011100;
    risePat = 10'b1000010000;
    fallPat = 10'b0001000010;
    do_reset;
    bus.en = 1'b1;
    tick;
    bus.div = 8'd5;
    bus.div_load = 1'b1;
    tick;
    bus.div_load = 1'b0;
    checks++; if (bus.clk_out !== 1'b0) begin failures++; $display("FAIL div5_old_period_clk got=%b exp=0", bus.clk_out); end
    checks++; if (bus.fall_pulse !== 1'b1) begin failures++; $display("FAIL div5_old_period_fall got=%b exp=1", bus.fall_pulse); end
    for (int i = 0; i < 10; i++) begin
      tick;
      expPer = (i < 5) ? 16'd2 : 16'd3;
      checks++; if (bus.clk_out !== clkPat[i]) begin failures++; $display("FAIL div5_clk[%0d] got=%b exp=%b", i, bus.clk_out, clkPat[i]); end
      checks++; if (bus.rise_pulse !== risePat[i]) begin failures++; $display("FAIL div5_rise[%0d] got=%b exp=%b", i, bus.rise_pulse, risePat[i]); end
      checks++; if (bus.fall_pulse !== fallPat[i]) begin failures++; $display("FAIL div5_fall[%0d] got=%b exp=%b", i, bus.fall_pulse, fallPat[i]); end
      checks++; if (bus.period_cnt !== expPer) begin failures++; $display("FAIL div5_period[%0d] got=%0d exp=%0d", i, bus.period_cnt, expPer); end
    end
  endtask

  task automatic test_div_change_midperiod;
    logic [0:9]        clkPat;
    logic [0:9]        risePat;
    logic [0:9]        fallPat;
    logic [PCNT_W-1:0] expPer;
    clkPat  = 10'b1110011001;
    risePat = 10'b1000010001;
    fallPat = 10'b0001000100;
    do_reset;
    preload(8'd5);
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      expPer = (i < 5) ? 16'd1 : ((i < 9) ? 16'd2 : 16'd3);
      checks++; if (bus.clk_out !== clkPat[i]) begin failures++; $display("FAIL chg_clk[%0d] got=%b exp=%b", i, bus.clk_out, clkPat[i]); end
      checks++; if (bus.rise_pulse !== risePat[i]) begin failures++; $display("FAIL chg_rise[%0d] got=%b exp=%b", i, bus.rise_pulse, risePat[i]); end
      checks++; if (bus.fall_pulse !== fallPat[i]) begin failures++; $display("FAIL chg_fall[%0d] got=%b exp=%b", i, bus.fall_pulse, fallPat[i]); end
      checks++; if (bus.period_cnt !== expPer) begin failures++; $display("FAIL chg_period[%0d] got=%0d exp=%0d", i, bus.period_cnt, expPer); end
      bus.div = 8'd4;
      bus.div_load = (i == 0);
    end
    bus.div_load = 1'b0;
  endtask

  task automatic test_stop;
    logic [0:6]        clkPat;
    logic [0:6]        risePat;
    logic [0:6]        fallPat;
    logic [0:6]        runPat;
    logic [PCNT_W-1:0] expPer;
    clkPat  = 7'b1100001;
    risePat = 7'b1000001;
    fallPat = 7'b0010000;
    runPat  = 7'b1111001;
    do_reset;
    preload(8'd4);
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      expPer = (i < 6) ? 16'd1 : 16'd2;
      checks++; if (bus.clk_out !== clkPat[i]) begin failures++; $display("FAIL stop_clk[%0d] got=%b exp=%b", i, bus.clk_out, clkPat[i]); end
      checks++; if (bus.rise_pulse !== risePat[i]) begin failures++; $display("FAIL stop_rise[%0d] got=%b exp=%b", i, bus.rise_pulse, risePat[i]); end
      checks++; if (bus.fall_pulse !== fallPat[i]) begin failures++; $display("FAIL stop_fall[%0d] got=%b exp=%b", i, bus.fall_pulse, fallPat[i]); end
      checks++; if (bus.running !== runPat[i]) begin failures++; $display("FAIL stop_running[%0d] got=%b exp=%b", i, bus.running, runPat[i]); end
      checks++; if (bus.period_cnt !== expPer) begin failures++; $display("FAIL stop_period[%0d] got=%0d exp=%0d", i, bus.period_cnt, expPer); end
      if (i == 0) bus.en = 1'b0;
      if (i == 5) bus.en = 1'b1;
    end
  endtask

  task automatic test_clamp;
    logic [0:3]        clkPat;
    logic [PCNT_W-1:0] expPer;
    logic [DIV_W-1:0]  v;
    clkPat = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      v = DIV_W'(k);
      do_reset;
      preload(v);
      bus.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick;
        expPer = PCNT_W'(i / 2 + 1);
        checks++; if (bus.clk_out !== clkPat[i]) begin failures++; $display("FAIL clamp%0d_clk[%0d] got=%b exp=%b", k, i, bus.clk_out, clkPat[i]); end
        checks++; if (bus.period_cnt !== expPer) begin failures++; $display("FAIL clamp%0d_period[%0d] got=%0d exp=%0d", k, i, bus.period_cnt, expPer); end
      end
    end
  endtask

  task automatic test_async_reset;
    logic [0:3]        clkPat;
    logic [PCNT_W-1:0] expPer;
    clkPat = 4'b1010;
    do_reset;
    preload(8'd4);
    bus.en = 1'b1;
    tick;
    checks++; if (bus.clk_out !== 1'b1) begin failures++; $display("FAIL arst_pre_clk got=%b exp=1", bus.clk_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.clk_out !== 1'b0) begin failures++; $display("FAIL arst_clk got=%b exp=0", bus.clk_out); end
    checks++; if (bus.rise_pulse !== 1'b0) begin failures++; $display("FAIL arst_rise got=%b exp=0", bus.rise_pulse); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL arst_running got=%b exp=0", bus.running); end
    checks++; if (bus.period_cnt !== 16'd0) begin failures++; $display("FAIL arst_period got=%0d exp=0", bus.period_cnt); end
    tick;
    checks++; if (bus.clk_out !== 1'b0) begin failures++; $display("FAIL arst_held_clk got=%b exp=0", bus.clk_out); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      expPer = PCNT_W'(i / 2 + 1);
      checks++; if (bus.clk_out !== clkPat[i]) begin failures++; $display("FAIL arst_restart_clk[%0d] got=%b exp=%b", i, bus.clk_out, clkPat[i]); end
      checks++; if (bus.period_cnt !== expPer) begin failures++; $display("FAIL arst_restart_period[%0d] got=%0d exp=%0d", i, bus.period_cnt, expPer); end
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.div = '0;
    bus.div_load = 1'b0;
    test_reset;
    test_default_div;
    test_div5;
    test_div_change_midperiod;
    test_stop;
    test_clamp;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
